// File: rtl/gmii_pkg.sv
// Shared types, constants and the byte-wise CRC32 step for the GMII transmit framer.
package gmii_pkg;

   typedef enum logic [3:0] {
      TX_IDLE,
      TX_PREAMBLE,
      TX_SFD,
      TX_DATA,
      TX_PAD,
      TX_FCS,
      TX_ERR,
      TX_DRAIN,
      TX_IFG
   } tx_state_e;

   localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
   localparam logic [7:0]  GMII_SFD      = 8'hD5;
   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

   // Reflected CRC32: fold the byte into the low bits, then shift out LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// Registered CRC32, one byte per cycle. init restarts from CRC32_INIT and may
// absorb a byte in the same cycle when en is also high.
module crc32_d8
   import gmii_pkg::*;
(
   input  logic        clk,
   input  logic        arst_n,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   logic [31:0] crc_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         crc_q <= CRC32_INIT;
      end else if (init) begin
         crc_q <= en ? crc32_byte(CRC32_INIT, data) : CRC32_INIT;
      end else if (en) begin
         crc_q <= crc32_byte(crc_q, data);
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, data, zero pad, FCS and inter-frame gap.
// Output registers are loaded with the byte that goes on the wire next cycle.
module gmii_tx_framer
   import gmii_pkg::*;
#(
   parameter int MIN_FRAME_BYTES = 60,
   parameter int IFG_CYCLES      = 12,
   parameter int PREAMBLE_LEN    = 7
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic [7:0] in_tdata,
   input  logic       in_tvalid,
   input  logic       in_tlast,
   output logic       in_tready,
   output logic [7:0] gmii_txd,
   output logic       gmii_txen,
   output logic       gmii_txer,
   output logic       frame_sent,
   output logic       underrun,
   output tx_state_e  dbg_state_o
);

   localparam int               IFGW     = $clog2(IFG_CYCLES + 2);
   localparam logic [IFGW-1:0]  IFG_LAST = IFGW'(IFG_CYCLES);
   localparam logic [11:0]      MIN_LEN  = 12'(MIN_FRAME_BYTES);
   localparam logic [10:0]      PRE_LAST = 11'(PREAMBLE_LEN - 1);

   tx_state_e       state_q;
   logic [10:0]     cnt_q;
   logic [IFGW-1:0] ifg_q;
   logic            last_seen_q;
   logic [7:0]      txd_q;
   logic            txen_q, txer_q, sent_q, underrun_q;

   logic            crc_init, crc_en;
   logic [7:0]      crc_data;
   logic [31:0]     crc, fcs;
   logic [7:0]      fcs_byte;
   logic [10:0]     cnt_inc;
   logic [11:0]     cnt_p1;
   logic [IFGW-1:0] ifg_inc;

   // Handshake: a byte moves when in_tvalid & in_tready; in_tready depends on state only.
   assign in_tready = (state_q == TX_SFD) || (state_q == TX_DATA) || (state_q == TX_DRAIN);

   assign fcs      = ~crc;
   assign fcs_byte = fcs[{cnt_q[1:0], 3'b000} +: 8];
   assign cnt_p1   = {1'b0, cnt_q} + 12'd1;
   assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
   assign ifg_inc  = (ifg_q == IFG_LAST) ? ifg_q : ifg_q + IFGW'(1);

   always_comb begin
      crc_init = (state_q == TX_SFD);
      crc_en   = 1'b0;
      crc_data = in_tdata;
      case (state_q)
         TX_SFD, TX_DATA: crc_en = in_tvalid;
         TX_PAD: begin
            crc_en   = 1'b1;
            crc_data = 8'h00;
         end
         default: ;
      endcase
   end

   crc32_d8 u_crc (
      .clk    (clk),
      .arst_n (arst_n),
      .init   (crc_init),
      .en     (crc_en),
      .data   (crc_data),
      .crc    (crc)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= TX_IDLE;
         cnt_q       <= '0;
         ifg_q       <= '0;
         last_seen_q <= 1'b0;
         txd_q       <= 8'h00;
         txen_q      <= 1'b0;
         txer_q      <= 1'b0;
         sent_q      <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         txer_q     <= 1'b0;
         sent_q     <= 1'b0;
         underrun_q <= 1'b0;
         case (state_q)
            TX_IDLE: begin
               txd_q  <= 8'h00;
               txen_q <= 1'b0;
               if (in_tvalid) begin
                  state_q <= TX_PREAMBLE;
                  txd_q   <= GMII_PREAMBLE;
                  txen_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            TX_PREAMBLE: begin
               txen_q <= 1'b1;
               if (cnt_q == PRE_LAST) begin
                  state_q     <= TX_SFD;
                  txd_q       <= GMII_SFD;
                  cnt_q       <= '0;
                  last_seen_q <= 1'b0;
               end else begin
                  txd_q <= GMII_PREAMBLE;
                  cnt_q <= cnt_inc;
               end
            end
            TX_SFD, TX_DATA: begin
               txen_q <= 1'b1;
               if (in_tvalid) begin
                  txd_q   <= in_tdata;
                  cnt_q   <= cnt_inc;
                  state_q <= TX_DATA;
                  if (in_tlast) begin
                     last_seen_q <= 1'b1;
                     if (cnt_p1 < MIN_LEN) begin
                        state_q <= TX_PAD;
                     end else begin
                        state_q <= TX_FCS;
                        cnt_q   <= '0;
                     end
                  end
               end else begin
                  // Source ran dry mid-frame: poison the frame instead of sending an FCS.
                  state_q    <= TX_ERR;
                  txd_q      <= 8'h00;
                  txer_q     <= 1'b1;
                  underrun_q <= 1'b1;
                  ifg_q      <= '0;
               end
            end
            TX_PAD: begin
               txen_q <= 1'b1;
               txd_q  <= 8'h00;
               cnt_q  <= cnt_inc;
               if (cnt_p1 >= MIN_LEN) begin
                  state_q <= TX_FCS;
                  cnt_q   <= '0;
               end
            end
            TX_FCS: begin
               txen_q <= 1'b1;
               txd_q  <= fcs_byte;
               cnt_q  <= cnt_inc;
               if (cnt_q[1:0] == 2'd3) begin
                  state_q <= TX_IFG;
                  sent_q  <= 1'b1;
                  ifg_q   <= '0;
               end
            end
            TX_ERR: begin
               txen_q  <= 1'b0;
               txd_q   <= 8'h00;
               ifg_q   <= ifg_inc;
               state_q <= last_seen_q ? TX_IFG : TX_DRAIN;
            end
            TX_DRAIN: begin
               txen_q <= 1'b0;
               txd_q  <= 8'h00;
               ifg_q  <= ifg_inc;
               if (in_tvalid && in_tlast) begin
                  state_q <= TX_IFG;
               end
            end
            TX_IFG: begin
               txen_q <= 1'b0;
               txd_q  <= 8'h00;
               // ifg_q counts from the cycle the last byte is on the wire.
               if (ifg_q == IFG_LAST) begin
                  if (in_tvalid) begin
                     state_q <= TX_PREAMBLE;
                     txd_q   <= GMII_PREAMBLE;
                     txen_q  <= 1'b1;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= TX_IDLE;
                  end
               end else begin
                  ifg_q <= ifg_inc;
               end
            end
            default: state_q <= TX_IDLE;
         endcase
      end
   end

   assign gmii_txd    = txd_q;
   assign gmii_txen   = txen_q;
   assign gmii_txer   = txer_q;
   assign frame_sent  = sent_q;
   assign underrun    = underrun_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: wire-level scoreboard, CRC residue, gaps and latency.
module tb_gmii_tx_framer;
   import gmii_pkg::*;

   logic       clk = 1'b0;
   logic       arst_n;
   logic [7:0] in_tdata;
   logic       in_tvalid, in_tlast, in_tready;
   logic [7:0] gmii_txd;
   logic       gmii_txen, gmii_txer, frame_sent, underrun;
   tx_state_e  dbg_state_o;

   gmii_tx_framer dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .in_tdata    (in_tdata),
      .in_tvalid   (in_tvalid),
      .in_tlast    (in_tlast),
      .in_tready   (in_tready),
      .gmii_txd    (gmii_txd),
      .gmii_txen   (gmii_txen),
      .gmii_txer   (gmii_txer),
      .frame_sent  (frame_sent),
      .underrun    (underrun),
      .dbg_state_o (dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   always #4 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [7:0] exp_q[$];
   logic [8:0] stim_q[$];
   int         len_q[$];
   int         gap_q[$];
   int         n_checks = 0;
   int         n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   // ---------------- monitor ----------------
   bit          in_frame = 0;
   bit          rdy_prev = 0;
   int          flen = 0, low_run = 0, fs_cnt = 0, fs_cyc = 0, err_cnt = 0;
   int          rise_cyc = 0, sfd_cyc = 0, rdy_cyc = 0, ur_cnt = 0, viol = 0;
   logic [31:0] res;

   always @(negedge clk) begin
      if (!arst_n) begin
         in_frame = 0;
         low_run  = 0;
         rdy_prev = 0;
      end else begin
         if (!gmii_txen && gmii_txd != 8'h00) viol++;
         if (gmii_txer && !gmii_txen) viol++;
         if (underrun != (gmii_txer && gmii_txen)) viol++;
         if (frame_sent && !gmii_txen) viol++;
         if (underrun) ur_cnt++;
         if (in_tready && !rdy_prev) rdy_cyc = cyc;
         rdy_prev = in_tready;
         if (gmii_txen) begin
            if (!in_frame) begin
               in_frame = 1;
               gap_q.push_back(low_run);
               rise_cyc = cyc;
               flen = 0; fs_cnt = 0; err_cnt = 0;
               res = 32'hFFFFFFFF;
            end
            if (flen == 7 && gmii_txd == 8'hD5) sfd_cyc = cyc;
            if (flen >= 8) res = crc_bit(res, gmii_txd);
            if (exp_q.size() > 0) check("wire_byte", 32'(gmii_txd), 32'(exp_q.pop_front()));
            else                  check("wire_extra_byte", 32'(gmii_txd), 32'hFFFF_FFFF);
            flen++;
            if (frame_sent) begin fs_cnt++; fs_cyc = cyc; end
            if (gmii_txer) err_cnt++;
         end else begin
            if (in_frame) begin
               in_frame = 0;
               len_q.push_back(flen);
               if (err_cnt == 0) begin
                  check("crc_residue", res, 32'hDEBB20E3);
                  check("frame_sent_count", fs_cnt, 1);
                  check("frame_sent_on_last_fcs", fs_cyc, cyc - 1);
               end else begin
                  check("err_cycles", err_cnt, 1);
                  check("frame_sent_in_err_frame", fs_cnt, 0);
               end
               low_run = 0;
            end
            low_run++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic queue_frame(input logic [7:0] base, input int len, input int err_after);
      logic [31:0] c, fcs;
      logic [7:0]  b;
      int          wire_len;
      for (int i = 0; i < len; i++) begin
         b = base + 8'(i);
         stim_q.push_back({(i == len - 1), b});
      end
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      if (err_after > 0) begin
         for (int i = 0; i < err_after; i++) exp_q.push_back(base + 8'(i));
         exp_q.push_back(8'h00);
      end else begin
         c = 32'hFFFFFFFF;
         wire_len = (len < 60) ? 60 : len;
         for (int i = 0; i < wire_len; i++) begin
            b = (i < len) ? base + 8'(i) : 8'h00;
            exp_q.push_back(b);
            c = crc_bit(c, b);
         end
         fcs = ~c;
         for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
      end
   endtask

   task automatic drive_stream(input int drop_after, input int stop_after);
      int   sent = 0;
      int   budget = 0;
      logic acc;
      while (stim_q.size() > 0 && budget < 3000) begin
         in_tvalid = 1'b1;
         in_tlast  = stim_q[0][8];
         in_tdata  = stim_q[0][7:0];
         @(negedge clk);
         acc = in_tready;
         @(posedge clk); #1;
         budget++;
         if (acc) begin
            void'(stim_q.pop_front());
            sent++;
            if (sent == stop_after) break;
            if (sent == drop_after) begin
               in_tvalid = 1'b0;
               @(posedge clk); #1;
            end
         end
      end
      if (stop_after == 0) begin
         in_tvalid = 1'b0; in_tlast = 1'b0; in_tdata = 8'h00;
      end
      check("drive_within_budget", 32'(budget < 3000), 1);
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      @(negedge clk);
      while ((dbg_state_o != TX_IDLE || gmii_txen) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check(tag, 32'(t < 2000), 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_txd"},       32'(gmii_txd), 0);
      check({tag, "_txen"},      32'(gmii_txen), 0);
      check({tag, "_txer"},      32'(gmii_txer), 0);
      check({tag, "_tready"},    32'(in_tready), 0);
      check({tag, "_framesent"}, 32'(frame_sent), 0);
      check({tag, "_underrun"},  32'(underrun), 0);
      check({tag, "_state"},     32'(dbg_state_o), 32'(TX_IDLE));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n, ur0;
      arst_n = 1'b0; in_tvalid = 1'b0; in_tlast = 1'b0; in_tdata = 8'h00;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #3;
      arst_n = 1'b1;
      repeat (2) @(posedge clk); #1;

      // 64-byte frame with latency measurement
      len_q.delete(); gap_q.delete();
      queue_frame(8'h00, 64, 0);
      n = cyc;
      drive_stream(0, 0);
      wait_idle("idle_after_64");
      check("len_64", len_q.size() > 0 ? len_q[0] : -1, 76);
      check("lat_txen_rise", rise_cyc, n + 1);
      check("lat_sfd", sfd_cyc, n + 8);
      check("lat_tready", rdy_cyc, n + 8);
      check("exp_empty_64", exp_q.size(), 0);

      // short frame, padded
      len_q.delete(); gap_q.delete();
      queue_frame(8'hAB, 1, 0);
      drive_stream(0, 0);
      wait_idle("idle_after_short");
      check("len_short", len_q.size() > 0 ? len_q[0] : -1, 72);
      check("exp_empty_short", exp_q.size(), 0);

      // back-to-back 60-byte frames
      len_q.delete(); gap_q.delete();
      queue_frame(8'h10, 60, 0);
      queue_frame(8'h80, 60, 0);
      drive_stream(0, 0);
      wait_idle("idle_after_b2b");
      check("b2b_frames", len_q.size(), 2);
      check("b2b_len0", len_q.size() > 0 ? len_q[0] : -1, 72);
      check("b2b_len1", len_q.size() > 1 ? len_q[1] : -1, 72);
      check("b2b_gap", gap_q.size() > 1 ? gap_q[1] : -1, 12);
      check("exp_empty_b2b", exp_q.size(), 0);

      // underrun after byte 10, then a clean frame
      len_q.delete(); gap_q.delete();
      ur0 = ur_cnt;
      queue_frame(8'h20, 100, 10);
      drive_stream(10, 0);
      queue_frame(8'h40, 60, 0);
      drive_stream(0, 0);
      wait_idle("idle_after_underrun");
      check("ur_pulses", ur_cnt - ur0, 1);
      check("ur_frames", len_q.size(), 2);
      check("ur_err_len", len_q.size() > 0 ? len_q[0] : -1, 19);
      check("ur_next_len", len_q.size() > 1 ? len_q[1] : -1, 72);
      check("ur_drain_low", 32'(gap_q.size() > 1 && gap_q[1] >= 90), 1);
      check("exp_empty_ur", exp_q.size(), 0);

      // asynchronous reset at data byte 20, then a clean frame
      len_q.delete(); gap_q.delete();
      queue_frame(8'h00, 64, 0);
      drive_stream(0, 20);
      #1;
      arst_n = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      in_tvalid = 1'b0; in_tlast = 1'b0;
      stim_q.delete(); exp_q.delete();
      repeat (2) @(posedge clk); #3;
      arst_n = 1'b1;
      @(negedge clk);
      check("post_rst_state", 32'(dbg_state_o), 32'(TX_IDLE));
      check("post_rst_tready", 32'(in_tready), 0);
      len_q.delete(); gap_q.delete();
      queue_frame(8'h33, 60, 0);
      drive_stream(0, 0);
      wait_idle("idle_after_rst_frame");
      check("rst_next_len", len_q.size() > 0 ? len_q[0] : -1, 72);
      check("exp_empty_rst", exp_q.size(), 0);

      check("protocol_violations", viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
